state_dump_seq: RTL and testbench
=================================

// Module: state_dump_seq
// PURPOSE
// - Debug read-out engine for the single-cycle datapath: walks the register file, then the data memory.
// - Streams every word out as a {kind, index, data} record over a valid/ready interface.
// - Sits beside the core. Started by the harness or a host after the program finishes.
// - Replaces fixed per-word probe ports with sequential read ports plus a stream.
// PARAMETERS
// - DATA_W  32  width of register/memory words
// - NREGS   32  number of register-file entries dumped (indices 0..NREGS-1)
// - NMEM    32  number of data-memory words dumped (word indices 0..NMEM-1)
// - IDX_W   5   width of index/address fields; must cover max(NREGS,NMEM)-1
// PORTS
// - clk          in   1       single clock; all state updates on rising edge
// - rst          in   1       synchronous, active-high reset
// - start        in   1       request a dump; sampled only in IDLE
// - busy         out  1       dump in progress
// - done         out  1       one-cycle pulse after the last record is accepted
// - reg_rd_addr  out  IDX_W   register-file read address (combinational read port)
// - reg_rd_data  in   DATA_W  register-file read data, valid same cycle as address
// - mem_rd_addr  out  IDX_W   data-memory word address (combinational read port)
// - mem_rd_data  in   DATA_W  data-memory read data, valid same cycle as address
// - out_valid    out  1       record fields valid
// - out_ready    in   1       consumer accepts record when out_valid && out_ready
// - out_kind     out  1       0 = register record, 1 = memory record
// - out_index    out  IDX_W   register number or memory word index
// - out_data     out  DATA_W  captured word
// BEHAVIOUR
// - Reset, and any cycle with rst=1 including mid-dump:
//   - state=IDLE, cnt=0, busy=0, done=0, out_valid=0.
//   - out_kind/out_index/out_data reset to 0.
//   - Any partially streamed record is dropped.
// - States:
//   - IDLE: start=1 -> RUN with cnt=0. start=0 -> stay.
//   - RUN: streams records cnt = 0 .. NREGS+NMEM-1.
//   - FIN: pulses done=1 for one cycle -> IDLE.
//   - busy=1 in RUN and FIN.
// - cnt is ceil(log2(NREGS+NMEM+1)) bits.
//   - cnt < NREGS: element is register cnt.
//   - Otherwise: element is memory word cnt-NREGS.
// - Read addresses are combinational from cnt and always driven.
//   - reg_rd_addr = cnt[IDX_W-1:0] while cnt < NREGS, else 0.
//   - mem_rd_addr = cnt-NREGS while cnt >= NREGS, else 0.
// - Load condition: in RUN, when (!out_valid || out_ready) and cnt < NREGS+NMEM.
//   - Next edge: out_* <= {kind, index, read data}, out_valid <= 1, cnt <= cnt+1.
// - Latency: start accepted at edge t -> record 0 (reg 0) has out_valid=1 after edge t+1.
// - Throughput: one record per cycle while out_ready=1, with no bubble at the reg->mem boundary.
// - Backpressure: while out_valid && !out_ready, every out_* field holds stable and cnt holds.
// - Completion: the handshake on the final record with cnt = NREGS+NMEM takes RUN -> FIN.
//   - On that edge out_valid <= 0.
//   - FIN lasts one cycle, with done=1 and busy=1.
//   - IDLE follows; done=0.
// - start while busy is ignored and does not restart or queue.
// - start on the same cycle as rst=1 is ignored.
// - Read data is sampled at the load edge, so register/memory writes after that edge do not alter a held record.
// STRUCTURE
// - Shared package dump_pkg holds:
//   - KIND_REG=1'b0 and KIND_MEM=1'b1.
//   - State encoding ST_IDLE/ST_RUN/ST_FIN.
// - Single flat module; no sub-module. The FSM, counter and output register are too small to split.
// - The top level wires reg_rd_* to a third register-file read port and mem_rd_* to a second data-memory read port.
// TESTING
// - Reset: hold rst 3 cycles -> busy=0, done=0, out_valid=0, out_data=0. start during rst -> no dump.
// - Full stream, out_ready=1, reg[k]=k+100, mem[k]=0xA000_0000+k:
//   - Exactly 64 records: 0..31 kind 0 data 100..131, then 32 kind 1 data 0xA0000000..0xA000001F.
//   - No gap at reg31->mem0.
//   - done pulses once, one cycle after the last handshake.
// - Backpressure: drop out_ready for 3 cycles while record reg 10 (data 110) is valid.
//   - out_kind/out_index/out_data hold 0/10/110.
//   - No record lost or duplicated.
//   - Total remains 64.
// - Start while busy: pulse start at record 20 -> stream unaffected, a single done.
//   - A start after done begins again at reg 0.
// - Reset mid-dump: assert rst during record mem 8 (cnt 40).
//   - Next cycle out_valid=0, busy=0, no done.
//   - A new start yields reg 0 first, and 64 records.
// - Hold-stability: change reg[5] from 105 to 7 while record 5 is stalled -> the emitted record still carries 105.

Source files
------------

// File: rtl/state_dump_seq_pkg.sv
// Shared constants for the state dump engine: record kinds and FSM encoding.
package dump_pkg;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } dump_state_t;

endpackage

// File: rtl/state_dump_seq_if.sv
// Record stream carrying {kind, index, data} with a valid/ready handshake.
interface dump_stream_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, out_kind, out_index, out_data, input out_ready);
    modport slave  (input out_valid, out_kind, out_index, out_data, output out_ready);
endinterface

// File: rtl/state_dump_seq.sv
// Debug read-out engine: walks the register file then data memory and streams
// each word as a {kind, index, data} record.
module state_dump_seq
    import dump_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NMEM   = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic [IDX_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    dump_stream_if.master     out_if
);

    localparam int CNT_W = $clog2(NREGS + NMEM + 1);
    localparam logic [CNT_W-1:0] C_NREGS = CNT_W'(NREGS);
    localparam logic [CNT_W-1:0] C_TOTAL = CNT_W'(NREGS + NMEM);

    dump_state_t       r_state;
    dump_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_kind;
    logic [IDX_W-1:0]  r_index;
    logic [DATA_W-1:0] r_data;

    logic              w_is_mem;
    logic [IDX_W-1:0]  w_mem_idx;
    logic              w_load;
    logic              w_last_hs;

    assign w_is_mem    = (r_cnt >= C_NREGS);
    assign w_mem_idx   = IDX_W'(r_cnt - C_NREGS);
    assign reg_rd_addr = w_is_mem ? '0 : r_cnt[IDX_W-1:0];
    assign mem_rd_addr = w_is_mem ? w_mem_idx : '0;

    // A slot frees up when the register is empty or being drained this cycle.
    assign w_load    = (r_state == ST_RUN) && (!r_valid || out_if.out_ready) && (r_cnt < C_TOTAL);
    assign w_last_hs = (r_state == ST_RUN) && r_valid && out_if.out_ready && (r_cnt == C_TOTAL);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_hs) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN) || (r_state == ST_FIN);
        done = (r_state == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_kind  <= 1'b0;
            r_index <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == ST_IDLE && start) r_cnt <= '0;
            if (w_load) begin
                r_valid <= 1'b1;
                r_kind  <= w_is_mem ? KIND_MEM : KIND_REG;
                r_index <= w_is_mem ? w_mem_idx : r_cnt[IDX_W-1:0];
                r_data  <= w_is_mem ? mem_rd_data : reg_rd_data;
                r_cnt   <= r_cnt + 1'b1;
            end else if (w_last_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = r_valid;
    assign out_if.out_kind  = r_kind;
    assign out_if.out_index = r_index;
    assign out_if.out_data  = r_data;

endmodule

// File: tb/tb_state_dump_seq.sv
// Directed bench for state_dump_seq: reset, full streams, backpressure,
// start-while-busy, mid-dump reset and hold stability.
module tb_state_dump_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [4:0]  reg_rd_addr, mem_rd_addr;
    logic [31:0] reg_rd_data, mem_rd_data;
    logic [31:0] regs [32];
    logic [31:0] mem  [32];
    int tests = 0;
    int fails = 0;

    dump_stream_if #(.DATA_W(32), .IDX_W(5)) sif ();

    always #5 clk = ~clk;

    assign reg_rd_data = regs[reg_rd_addr];
    assign mem_rd_data = mem[mem_rd_addr];

    state_dump_seq #(.DATA_W(32), .NREGS(32), .NMEM(32), .IDX_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_if      (sif)
    );

    function automatic logic [31:0] exp_data(input int r);
        return (r < 32) ? 32'(r + 100) : 32'hA000_0000 + 32'(r - 32);
    endfunction

    function automatic logic exp_kind(input int r);
        return (r >= 32);
    endfunction

    function automatic logic [4:0] exp_idx(input int r);
        return (r < 32) ? 5'(r) : 5'(r - 32);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_lat_novalid", 64'(sif.out_valid), 64'd0);
    endtask

    // Consume one full dump, optionally stalling on one record, pulsing start
    // mid-stream, or overwriting reg[5] while stalled.
    task automatic consume(input string tag, input int stall_rec, input int stall_len,
                           input int start_rec, input bit mod_reg5);
        int rec = 0, cyc = 0, stall = 0, gaps = 0, first_cyc = -1;
        int done_cnt = 0, done_cyc = -1, last_cyc = -1, hold_bad = 0;
        bit pulsed = 0;
        sif.out_ready = 1'b1;
        while (cyc < 400 && !(rec == 64 && cyc >= last_cyc + 3)) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (start_rec >= 0 && !pulsed && sif.out_valid && rec == start_rec) begin
                start = 1'b1;
                pulsed = 1;
            end
            if (sif.out_valid && rec == stall_rec && stall < stall_len) begin
                sif.out_ready = 1'b0;
                if (mod_reg5 && stall == 0) regs[5] = 32'd7;
                if (sif.out_kind !== exp_kind(rec) || sif.out_index !== exp_idx(rec) ||
                    sif.out_data !== exp_data(rec) || busy !== 1'b1) hold_bad++;
                stall++;
            end else begin
                sif.out_ready = 1'b1;
            end
            if (sif.out_valid && sif.out_ready) begin
                if (rec == 0) first_cyc = cyc;
                if (rec < 64 && (sif.out_kind !== exp_kind(rec) || sif.out_index !== exp_idx(rec) ||
                    sif.out_data !== exp_data(rec))) begin
                    check({tag, "_rec_kind"}, 64'(sif.out_kind), 64'(exp_kind(rec)));
                    check({tag, "_rec_index"}, 64'(sif.out_index), 64'(exp_idx(rec)));
                    check({tag, "_rec_data"}, 64'(sif.out_data), 64'(exp_data(rec)));
                end
                rec++;
                if (rec == 64) last_cyc = cyc;
            end else if (!sif.out_valid && rec > 0 && rec < 64) begin
                gaps++;
            end
        end
        start = 1'b0;
        regs[5] = 32'd105;
        check({tag, "_records"}, 64'(rec), 64'd64);
        check({tag, "_first_latency"}, 64'(first_cyc), 64'd1);
        check({tag, "_gaps"}, 64'(gaps), 64'd0);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_timing"}, 64'(done_cyc), 64'(last_cyc + 1));
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        if (stall_len > 0) begin
            check({tag, "_stall_cycles"}, 64'(stall), 64'(stall_len));
            check({tag, "_hold_stable"}, 64'(hold_bad), 64'd0);
        end
    endtask

    initial begin
        int found, done_seen;
        sif.out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            regs[k] = 32'(k + 100);
            mem[k]  = 32'hA000_0000 + 32'(k);
        end

        // Reset held 3 cycles with start asserted throughout
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(sif.out_valid), 64'd0);
        check("rst_data", 64'(sif.out_data), 64'd0);
        check("rst_kind_index", {58'd0, sif.out_kind, sif.out_index}, 64'd0);
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ignored", 64'(busy), 64'd0);

        start_dump();
        consume("full", -1, 0, -1, 1'b0);

        start_dump();
        consume("bp", 10, 3, -1, 1'b0);

        start_dump();
        consume("busy_start", -1, 0, 20, 1'b0);

        // Reset mid-dump while mem word 8 is on the output
        start_dump();
        found = 0;
        sif.out_ready = 1'b1;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(posedge clk); #1;
            if (sif.out_valid && sif.out_kind === 1'b1 && sif.out_index === 5'd8) found = 1;
        end
        check("midrst_reached_mem8", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", 64'(sif.out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        done_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrst_quiet", 64'(done_seen), 64'd0);
        start_dump();
        consume("after_rst", -1, 0, -1, 1'b0);

        start_dump();
        consume("hold", 5, 3, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
